// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC output stage: widths, sector codes and Q9.8 angle constants.
package cordic_pkg;

    localparam int IN_WIDTH          = 16;
    localparam int FRAC_WIDTH        = 8;
    localparam int OUT_DEG_WIDTH     = 17;
    localparam int OUT_XY_WIDTH      = 17;
    localparam int SECTOR_FLAG_WIDTH = 2;
    localparam int PIPE_LATENCY      = 6;
    localparam int FIFO_DEPTH        = 4;
    localparam int DROP_CNT_WIDTH    = 8;

    localparam int RESULT_WIDTH = OUT_DEG_WIDTH + 2 * OUT_XY_WIDTH + 1;
    localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [SECTOR_FLAG_WIDTH-1:0] SECT_Q0 = 2'd0;
    localparam logic [SECTOR_FLAG_WIDTH-1:0] SECT_Q1 = 2'd1;
    localparam logic [SECTOR_FLAG_WIDTH-1:0] SECT_Q2 = 2'd2;
    localparam logic [SECTOR_FLAG_WIDTH-1:0] SECT_Q3 = 2'd3;

    localparam logic [OUT_DEG_WIDTH-1:0] DEG_90        = 17'h05A00;
    localparam logic [OUT_DEG_WIDTH-1:0] DEG_180       = 17'h0B400;
    localparam logic [OUT_DEG_WIDTH-1:0] DEG_270       = 17'h10E00;
    localparam logic [OUT_DEG_WIDTH-1:0] DEG_360       = 17'h16800;
    localparam logic [OUT_DEG_WIDTH-1:0] DEG_UNDERFLOW = 17'h06000;

    function automatic logic [OUT_XY_WIDTH-1:0] neg_xy(input logic [OUT_XY_WIDTH-1:0] v);
        return (~v) + OUT_XY_WIDTH'(1);
    endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Synchronous FIFO holding restored CORDIC results; caller guarantees no push into a full buffer
// unless a pop happens in the same cycle.
module cordic_result_fifo #(
    parameter int DATA_W = 52,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cordic_sector_restore.sv
// CORDIC output stage: valid tagging, sector fold-back, result buffering and drop accounting.
// Define CORDIC_RESTORE_DROP_CNT_EN to build the saturating drop counter.
module cordic_sector_restore
    import cordic_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [IN_WIDTH-1:0]          pipe_degree,
    input  logic [IN_WIDTH-1:0]          pipe_x,
    input  logic [IN_WIDTH-1:0]          pipe_y,
    input  logic [SECTOR_FLAG_WIDTH-1:0] pipe_sector,
    input  logic                         pipe_arctan_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_DEG_WIDTH-1:0]     out_degree,
    output logic [OUT_XY_WIDTH-1:0]      out_x,
    output logic [OUT_XY_WIDTH-1:0]      out_y,
    output logic                         out_arctan_en,
    output logic [DROP_CNT_WIDTH-1:0]    drop_cnt,
    output logic                         overflow
);

    logic [PIPE_LATENCY-1:0]  vld_q, vld_d;
    logic                     tag_valid;
    logic [OUT_DEG_WIDTH-1:0] theta_ext, theta_c, deg_raw, deg_f;
    logic [OUT_XY_WIDTH-1:0]  c_ext, s_ext, x_f, y_f;
    logic                     fix_valid_q, fix_valid_d;
    logic [RESULT_WIDTH-1:0]  fix_data_q, fix_data_d;
    logic [RESULT_WIDTH-1:0]  head_data;
    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
    logic [FIFO_CNT_W-1:0]    fifo_count;
    logic                     overflow_q, overflow_d;

    always_comb vld_d = {vld_q[PIPE_LATENCY-2:0], in_valid};
    assign tag_valid = vld_q[PIPE_LATENCY-1];

    always_comb begin
        theta_ext = OUT_DEG_WIDTH'(pipe_degree);
        theta_c   = theta_ext;
        // Large codes come from the CORDIC residual going slightly negative.
        if (theta_ext >= DEG_UNDERFLOW) theta_c = '0;
        else if (theta_ext > DEG_90)    theta_c = DEG_90;
    end

    always_comb begin
        c_ext   = OUT_XY_WIDTH'(pipe_x);
        s_ext   = OUT_XY_WIDTH'(pipe_y);
        deg_raw = theta_c;
        x_f     = c_ext;
        y_f     = s_ext;
        if (pipe_arctan_en) begin
            unique case (pipe_sector)
                SECT_Q0: deg_raw = theta_c;
                SECT_Q1: deg_raw = DEG_180 - theta_c;
                SECT_Q2: deg_raw = DEG_180 + theta_c;
                SECT_Q3: deg_raw = DEG_360 - theta_c;
                default: deg_raw = theta_c;
            endcase
        end else begin
            unique case (pipe_sector)
                SECT_Q0: begin deg_raw = theta_c;           x_f = c_ext;         y_f = s_ext;         end
                SECT_Q1: begin deg_raw = DEG_90 + theta_c;  x_f = neg_xy(s_ext); y_f = c_ext;         end
                SECT_Q2: begin deg_raw = DEG_180 + theta_c; x_f = neg_xy(c_ext); y_f = neg_xy(s_ext); end
                SECT_Q3: begin deg_raw = DEG_270 + theta_c; x_f = s_ext;         y_f = neg_xy(c_ext); end
                default: begin deg_raw = theta_c;           x_f = c_ext;         y_f = s_ext;         end
            endcase
        end
        deg_f = (deg_raw == DEG_360) ? '0 : deg_raw;
    end

    always_comb begin
        fix_valid_d = tag_valid;
        fix_data_d  = fix_data_q;
        if (tag_valid) fix_data_d = {deg_f, x_f, y_f, pipe_arctan_en};
    end

    // A full buffer can still take a result when the consumer drains the head that same cycle.
    assign fifo_pop   = ~fifo_empty & out_ready;
    assign fifo_push  = fix_valid_q & ((fifo_count < FIFO_CNT_W'(FIFO_DEPTH)) | fifo_pop);
    assign drop       = fix_valid_q & fifo_full & ~fifo_pop;
    assign overflow_d = overflow_q | drop;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            fix_valid_q <= 1'b0;
            fix_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            fix_valid_q <= fix_valid_d;
            fix_data_q  <= fix_data_d;
            overflow_q  <= overflow_d;
        end
    end

    cordic_result_fifo #(
        .DATA_W (RESULT_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fix_data_q),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign {out_degree, out_x, out_y, out_arctan_en} = fifo_empty ? '0 : head_data;
    assign overflow  = overflow_q;

`ifdef CORDIC_RESTORE_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cordic_sector_restore.sv
// Directed bench for cordic_sector_restore: fold-back, latency, clamping, back-pressure, drops, reset.
module tb_cordic_sector_restore;

`ifdef CORDIC_RESTORE_DROP_CNT_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] pipe_degree = '0, pipe_x = '0, pipe_y = '0;
    logic [1:0]  pipe_sector = '0;
    logic        pipe_arctan_en = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [16:0] out_degree, out_x, out_y;
    logic        out_arctan_en;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [15:0] v_deg [8];
    logic [15:0] v_x   [8];
    logic [15:0] v_y   [8];
    logic [1:0]  v_sec [8];
    logic        v_mode[8];

    cordic_sector_restore dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .pipe_degree    (pipe_degree),
        .pipe_x         (pipe_x),
        .pipe_y         (pipe_y),
        .pipe_sector    (pipe_sector),
        .pipe_arctan_en (pipe_arctan_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_degree     (out_degree),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_arctan_en  (out_arctan_en),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic mode, input logic [1:0] sec,
                           input logic [15:0] deg, input logic [15:0] x, input logic [15:0] y);
        v_mode[i] = mode; v_sec[i] = sec; v_deg[i] = deg; v_x[i] = x; v_y[i] = y;
    endtask

    // Issues n back-to-back samples; pipeline results appear PIPE_LATENCY cycles after each in_valid.
    // Returns in the cycle the last result sits in the fixup register.
    task automatic stream(input int n);
        for (int c = 0; c < n + 6; c++) begin
            in_valid = (c < n);
            if (c >= 6 && c - 6 < n) begin
                pipe_degree    = v_deg[c-6];
                pipe_x         = v_x[c-6];
                pipe_y         = v_y[c-6];
                pipe_sector    = v_sec[c-6];
                pipe_arctan_en = v_mode[c-6];
            end else begin
                pipe_degree = 16'hBEEF; pipe_x = 16'h1234; pipe_y = 16'h5678;
                pipe_sector = 2'd2;     pipe_arctan_en = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [16:0] deg, input logic [16:0] x,
                               input logic [16:0] y, input logic mode);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_deg"}, out_degree, deg);
        check({tag, "_x"}, out_x, x);
        check({tag, "_y"}, out_y, y);
        check({tag, "_mode"}, out_arctan_en, mode);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic single(input string tag, input logic [16:0] deg, input logic [16:0] x,
                          input logic [16:0] y, input logic mode);
        stream(1);
        check({tag, "_lat7"}, out_valid, 0);
        tick();
        expect_head(tag, deg, x, y, mode);
        check({tag, "_empty"}, out_valid, 0);
    endtask

    initial begin
        int seen;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_deg", out_degree, 0);
        check("rst_x", out_x, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // Vectoring s1: 180-30 = 150 deg
        set_vec(0, 1'b1, 2'd1, 16'h1E00, 16'h0123, 16'h0045);
        single("vec_s1", 17'h09600, 17'h00123, 17'h00045, 1'b1);

        // Rotation s2: 180+30, (-c,-s)
        set_vec(0, 1'b0, 2'd2, 16'h1E00, 16'h00DD, 16'h0080);
        single("rot_s2", 17'h0D200, 17'h1FF23, 17'h1FF80, 1'b0);

        // Rotation s1: 90+10, (-s,c)
        set_vec(0, 1'b0, 2'd1, 16'h0A00, 16'h0100, 16'h0040);
        single("rot_s1", 17'h06400, 17'h1FFC0, 17'h00100, 1'b0);

        // Rotation s3: 270+16, (s,-c)
        set_vec(0, 1'b0, 2'd3, 16'h1000, 16'h0080, 16'h0020);
        single("rot_s3", 17'h11E00, 17'h00020, 17'h1FF80, 1'b0);

        // Vectoring s3 wrap, underflow clamp, upper clamp, s2
        set_vec(0, 1'b1, 2'd3, 16'h0000, 16'h0010, 16'h0000);
        single("vec_wrap", 17'h00000, 17'h00010, 17'h00000, 1'b1);
        set_vec(0, 1'b1, 2'd3, 16'hFF80, 16'h0011, 16'h0001);
        single("vec_uflow", 17'h00000, 17'h00011, 17'h00001, 1'b1);
        set_vec(0, 1'b1, 2'd0, 16'h5B00, 16'h0012, 16'h0002);
        single("vec_clamp", 17'h05A00, 17'h00012, 17'h00002, 1'b1);
        set_vec(0, 1'b1, 2'd2, 16'h2D00, 16'h0013, 16'h0003);
        single("vec_s2", 17'h0E100, 17'h00013, 17'h00003, 1'b1);

        // Back-pressure: 6 results into a 4-deep buffer
        for (int i = 0; i < 6; i++)
            set_vec(i, 1'b1, 2'd0, 16'((i + 1) * 256), 16'(16 + i), 16'(32 + i));
        stream(6);
        tick();
        tick();
        check("bp_drop", drop_cnt, EXP_DROP);
        check("bp_ovf", overflow, 1);
        expect_head("bp0", 17'h00100, 17'h00010, 17'h00020, 1'b1);
        expect_head("bp1", 17'h00200, 17'h00011, 17'h00021, 1'b1);
        expect_head("bp2", 17'h00300, 17'h00012, 17'h00022, 1'b1);
        expect_head("bp3", 17'h00400, 17'h00013, 17'h00023, 1'b1);
        check("bp_empty", out_valid, 0);

        // Full buffer with simultaneous pop and push
        for (int i = 0; i < 5; i++)
            set_vec(i, 1'b0, 2'd0, 16'(16'h0A00 + i * 256), 16'(64 + i), 16'(80 + i));
        stream(5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("pp_drop", drop_cnt, EXP_DROP);
        check("pp_ovf", overflow, 1);
        expect_head("pp1", 17'h00B00, 17'h00041, 17'h00051, 1'b0);
        expect_head("pp2", 17'h00C00, 17'h00042, 17'h00052, 1'b0);
        expect_head("pp3", 17'h00D00, 17'h00043, 17'h00053, 1'b0);
        expect_head("pp4", 17'h00E00, 17'h00044, 17'h00054, 1'b0);
        check("pp_empty", out_valid, 0);

        // Reset with one result buffered and three samples in flight
        set_vec(0, 1'b1, 2'd0, 16'h0100, 16'h0001, 16'h0001);
        stream(1);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_valid", out_valid, 0);
        check("rr_drop", drop_cnt, 0);
        check("rr_ovf", overflow, 0);
        check("rr_deg", out_degree, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            pipe_degree = 16'h1000; pipe_x = 16'h0077; pipe_y = 16'h0066;
            pipe_sector = 2'd1;     pipe_arctan_en = 1'b1;
            tick();
            if (out_valid) seen++;
        end
        check("rr_stale", 32'(seen), 0);

        set_vec(0, 1'b1, 2'd1, 16'h2000, 16'h0050, 16'h0005);
        single("post_rst", 17'h09400, 17'h00050, 17'h00005, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
